// File: rtl/sram_access_ctrl.sv
// Access sequencer for a row-organised 6T SRAM array: precharge, word line, write/sense, recovery.
// Optional write-verify read-back is enabled by defining SRAM_CTRL_WRITE_VERIFY_EN.
module sram_access_ctrl #(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8,
  parameter int PRE_CYC = 1,
  parameter int WL_CYC  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  output logic                     rdy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic                     ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     err,
  output logic                     pre,
  output logic [(1<<ADDR_W)-1:0]   wl,
  output logic                     wen,
  output logic [DATA_W-1:0]        bl_drv,
  output logic                     sae,
  input  logic [DATA_W-1:0]        sa_out
);

  localparam int ROWS    = 1 << ADDR_W;
  localparam int CNT_MAX = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] WL_LAST  = CNT_W'(WL_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRECH,
    WLON,
    SENSE,
    RECOV
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
    ,
    VPRE,
    VWL,
    VSENSE
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                accept;
  logic                rdy_d, ack_d, err_d, pre_d, wen_d, sae_d;
  logic [ROWS-1:0]     wl_d;
  logic [DATA_W-1:0]   bl_drv_d, rdata_d;
  logic                wl_phase;

  // Outputs are computed from the next state so every array control comes straight off a flop.
  always_comb begin
    accept   = req & rdy;
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    row_d    = row_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata;
    err_d    = 1'b0;

    if (accept) begin
      row_d   = addr;
      we_d    = we;
      wdata_d = wdata;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) state_d = PRECH;
      end
      PRECH: begin
        if (cnt_q == PRE_LAST) begin
          state_d = WLON;
          cnt_d   = '0;
        end
      end
      WLON: begin
        if (cnt_q == WL_LAST) begin
          cnt_d = '0;
          if (!we_q) begin
            state_d = SENSE;
          end else begin
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
            state_d = VPRE;
`else
            state_d = RECOV;
`endif
          end
        end
      end
      SENSE: begin
        state_d = RECOV;
        cnt_d   = '0;
        rdata_d = sa_out;
      end
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
      VPRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = VWL;
          cnt_d   = '0;
        end
      end
      VWL: begin
        if (cnt_q == WL_LAST) begin
          state_d = VSENSE;
          cnt_d   = '0;
        end
      end
      VSENSE: begin
        state_d = RECOV;
        cnt_d   = '0;
        err_d   = (sa_out != wdata_q);
      end
`endif
      RECOV: begin
        cnt_d   = '0;
        state_d = accept ? PRECH : IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    wl_phase = (state_d == WLON) || (state_d == SENSE);
    pre_d    = (state_d == PRECH);
    sae_d    = (state_d == SENSE);
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
    wl_phase = wl_phase || (state_d == VWL) || (state_d == VSENSE);
    pre_d    = pre_d || (state_d == VPRE);
    sae_d    = sae_d || (state_d == VSENSE);
`endif
    wl_d     = wl_phase ? (ROWS'(1) << row_d) : '0;
    wen_d    = (state_d == WLON) && we_d;
    bl_drv_d = wen_d ? wdata_d : '0;
    ack_d    = (state_d == RECOV);
    rdy_d    = (state_d == IDLE) || (state_d == RECOV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdy     <= 1'b1;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      pre     <= 1'b0;
      wl      <= '0;
      wen     <= 1'b0;
      bl_drv  <= '0;
      sae     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdy     <= rdy_d;
      ack     <= ack_d;
      err     <= err_d;
      rdata   <= rdata_d;
      pre     <= pre_d;
      wl      <= wl_d;
      wen     <= wen_d;
      bl_drv  <= bl_drv_d;
      sae     <= sae_d;
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a behavioural 8x8 6T array model and per-cycle invariant checks.
// Defining SRAM_CTRL_WRITE_VERIFY_EN adds the write-verify scenarios and shifts write ACK timing.
module tb_sram_access_ctrl;

  localparam int ROWS = 8;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
  localparam int WR_ACK = 8;
`else
  localparam int WR_ACK = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        rdy;
  logic        we;
  logic [2:0]  addr;
  logic [7:0]  wdata;
  logic        ack;
  logic [7:0]  rdata;
  logic        err;
  logic        pre;
  logic [7:0]  wl;
  logic        wen;
  logic [7:0]  bl_drv;
  logic        sae;
  logic [7:0]  sa_out;

  logic [7:0]  mem [ROWS] = '{default: 8'h00};
  logic        stuck_en = 1'b0;
  logic        cur_we = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  sram_access_ctrl #(.ADDR_W(3), .DATA_W(8), .PRE_CYC(1), .WL_CYC(2)) dut (
    .clk(clk), .rst(rst), .req(req), .rdy(rdy), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err), .pre(pre), .wl(wl), .wen(wen),
    .bl_drv(bl_drv), .sae(sae), .sa_out(sa_out)
  );

  always #5 clk = ~clk;

  // Cell array: the selected row stores BL_DRV while WL and WEN are high; row 5 bit 0 may be stuck at 0.
  always @(posedge clk) begin
    if (wen) begin
      for (int i = 0; i < ROWS; i++) begin
        if (wl[i]) mem[i] <= (stuck_en && i == 5) ? (bl_drv & 8'hFE) : bl_drv;
      end
    end
  end

  always_comb begin
    sa_out = 8'h00;
    for (int i = 0; i < ROWS; i++) begin
      if (wl[i]) sa_out = mem[i];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("inv_pre_wl", 32'(pre & (|wl)), 0);
    checkOutput("inv_onehot", 32'($onehot0(wl)), 1);
    checkOutput("inv_wen_wl", 32'(wen & ~(|wl)), 0);
    checkOutput("inv_sae_wl", 32'(sae & ~(|wl)), 0);
    checkOutput("inv_wen_sae", 32'(wen & sae), 0);
    checkOutput("inv_bl_zero", 32'(!wen && (bl_drv != 8'h00)), 0);
`ifndef SRAM_CTRL_WRITE_VERIFY_EN
    checkOutput("inv_sae_read", 32'(sae & cur_we), 0);
`endif
  end

  // Presents a request and returns just after the accepting edge (edge 0); REQ is left high.
  task automatic applyStimulus(input logic w, input logic [2:0] a, input logic [7:0] d);
    int waited = 0;
    req = 1'b1; we = w; addr = a; wdata = d;
    while (!rdy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("accept_rdy", 32'(rdy), 1);
    @(posedge clk);
    cur_we = w;
    #1;
  endtask

  task automatic waitAck(input int start, input int exp, input string tag);
    int c = start;
    do begin
      @(negedge clk);
      c++;
    end while (!ack && c < start + 40);
    checkOutput(tag, c, exp);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_rdy"}, 32'(rdy), 1);
    checkOutput({tag, "_ack"}, 32'(ack), 0);
    checkOutput({tag, "_err"}, 32'(err), 0);
    checkOutput({tag, "_rdata"}, 32'(rdata), 0);
    checkOutput({tag, "_pre"}, 32'(pre), 0);
    checkOutput({tag, "_wl"}, 32'(wl), 0);
    checkOutput({tag, "_wen"}, 32'(wen), 0);
    checkOutput({tag, "_bl"}, 32'(bl_drv), 0);
    checkOutput({tag, "_sae"}, 32'(sae), 0);
  endtask

  initial begin
    int ack_seen;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 3'd0; wdata = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;

    // Write 0xA5 to row 3 while ADDR/WDATA wander after accept.
    applyStimulus(1'b1, 3'd3, 8'hA5);
    req = 1'b0; addr = 3'd6; wdata = 8'h5A;
    @(negedge clk);
    checkOutput("wr_c1_pre", 32'(pre), 1);
    checkOutput("wr_c1_wl", 32'(wl), 0);
    checkOutput("wr_c1_rdy", 32'(rdy), 0);
    addr = 3'd1; wdata = 8'hFF;
    @(negedge clk);
    checkOutput("wr_c2_pre", 32'(pre), 0);
    checkOutput("wr_c2_wl", 32'(wl), 32'h08);
    checkOutput("wr_c2_wen", 32'(wen), 1);
    checkOutput("wr_c2_bl", 32'(bl_drv), 32'hA5);
    addr = 3'd7; wdata = 8'h00;
    @(negedge clk);
    checkOutput("wr_c3_wl", 32'(wl), 32'h08);
    checkOutput("wr_c3_wen", 32'(wen), 1);
    checkOutput("wr_c3_bl", 32'(bl_drv), 32'hA5);
    waitAck(3, WR_ACK, "wr_ack_cycle");
    checkOutput("wr_ack_err", 32'(err), 0);
    checkOutput("wr_ack_wl", 32'(wl), 0);
    checkOutput("wr_ack_rdy", 32'(rdy), 1);
    checkOutput("wr_mem3", 32'(mem[3]), 32'hA5);

    // Read row 3 back.
    @(negedge clk);
    applyStimulus(1'b0, 3'd3, 8'h00);
    req = 1'b0; addr = 3'd0;
    @(negedge clk);
    checkOutput("rd_c1_pre", 32'(pre), 1);
    checkOutput("rd_c1_sae", 32'(sae), 0);
    addr = 3'd5;
    @(negedge clk);
    checkOutput("rd_c2_wl", 32'(wl), 32'h08);
    checkOutput("rd_c2_sae", 32'(sae), 0);
    @(negedge clk);
    checkOutput("rd_c3_wl", 32'(wl), 32'h08);
    checkOutput("rd_c3_sae", 32'(sae), 0);
    @(negedge clk);
    checkOutput("rd_c4_wl", 32'(wl), 32'h08);
    checkOutput("rd_c4_sae", 32'(sae), 1);
    checkOutput("rd_c4_ack", 32'(ack), 0);
    @(negedge clk);
    checkOutput("rd_c5_ack", 32'(ack), 1);
    checkOutput("rd_c5_rdata", 32'(rdata), 32'hA5);
    checkOutput("rd_c5_sae", 32'(sae), 0);
    checkOutput("rd_c5_wl", 32'(wl), 0);

    // Back-to-back: write 0x3C to row 1 then read row 1 with REQ held high.
    @(negedge clk);
    applyStimulus(1'b1, 3'd1, 8'h3C);
    we = 1'b0; addr = 3'd1; wdata = 8'h00;
    waitAck(0, WR_ACK, "b2b_wr_ack");
    checkOutput("b2b_ack_rdy", 32'(rdy), 1);
    checkOutput("b2b_ack_pre", 32'(pre), 0);
    @(posedge clk);
    cur_we = 1'b0;
    #1 req = 1'b0;
    @(negedge clk);
    checkOutput("b2b_rd_c1_pre", 32'(pre), 1);
    checkOutput("b2b_rd_c1_ack", 32'(ack), 0);
    waitAck(1, 5, "b2b_rd_ack");
    checkOutput("b2b_rd_rdata", 32'(rdata), 32'h3C);
    checkOutput("b2b_mem1", 32'(mem[1]), 32'h3C);

`ifdef SRAM_CTRL_WRITE_VERIFY_EN
    // Verify against a stuck-at-0 bit on row 5, then on a healthy row.
    @(negedge clk);
    stuck_en = 1'b1;
    applyStimulus(1'b1, 3'd5, 8'hFF);
    req = 1'b0;
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      checkOutput("vfy_err_quiet", 32'(err), 0);
      checkOutput("vfy_ack_quiet", 32'(ack), 0);
    end
    @(negedge clk);
    checkOutput("vfy_c8_ack", 32'(ack), 1);
    checkOutput("vfy_c8_err", 32'(err), 1);
    checkOutput("vfy_rdata_kept", 32'(rdata), 32'h3C);
    checkOutput("vfy_mem5", 32'(mem[5]), 32'hFE);
    @(negedge clk);
    checkOutput("vfy_err_after", 32'(err), 0);
    applyStimulus(1'b1, 3'd6, 8'h96);
    req = 1'b0;
    waitAck(0, 8, "vfy_ok_ack");
    checkOutput("vfy_ok_err", 32'(err), 0);
`endif

    // Reset during WLON of a read drops the operation.
    @(negedge clk);
    applyStimulus(1'b0, 3'd2, 8'h00);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_pre_wl", 32'(wl), 32'h04);
    rst = 1'b1;
    @(negedge clk);
    checkIdleOutputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    ack_seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (ack || pre) ack_seen++;
    end
    checkOutput("rst_no_ack", ack_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("[TB] FAIL global_timeout: got expired expected done");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
